// File: rtl/dmem_store_buffer_if.sv
// Bus bundle for the committed-store buffer.
// Carries the store handshake from the pipeline, the load lookup path,
// the memory write/read port signals and the occupancy status.
//   master : the environment (pipeline + data memory)
//   slave  : the store buffer itself
// DEPTH must match the DEPTH of the dmem_store_buffer it connects to;
// it only sizes the count field.
interface dmem_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          drain_en;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_fwd;
  logic          mem_write;
  logic [31:0]   mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_raddr;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, drain_en, ld_addr, mem_rdata,
    input  st_ready, ld_data, ld_fwd, mem_write, mem_waddr, mem_wdata,
           mem_raddr, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, drain_en, ld_addr, mem_rdata,
    output st_ready, ld_data, ld_fwd, mem_write, mem_waddr, mem_wdata,
           mem_raddr, count, empty
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Committed-store buffer in front of a word-addressed data memory.
// Stores are queued in order and drained one per cycle to the memory
// write port; loads read memory combinationally but are served from the
// youngest buffered store to the same word when one exists.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : dmem_store_buffer_if.slave (store handshake, drain enable,
//           load path, memory ports, count/empty status)
// Address bits [1:0] are ignored everywhere (word granularity).
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_store_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [29:0]    ent_addr [DEPTH];
  logic [31:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count_q;
  logic           push;
  logic           pop;
  logic           fwd_hit;
  logic [31:0]    fwd_data;
  logic [PW-1:0]  scan_idx;
  logic           unused_st_lsb;

  assign unused_st_lsb = ^bus.st_addr[1:0];

  // No full-bypass: a full buffer refuses stores even when draining.
  assign bus.st_ready  = rst_n && (count_q != FULL_CNT);
  assign push          = bus.st_valid && bus.st_ready;
  assign bus.mem_write = rst_n && (count_q != '0) && bus.drain_en;
  assign pop           = bus.mem_write;

  assign bus.mem_waddr = {ent_addr[head], 2'b00};
  assign bus.mem_wdata = ent_data[head];
  assign bus.mem_raddr = bus.ld_addr;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);

  // Scan oldest to youngest so the last match wins. The head entry that
  // is draining this cycle is still valid and therefore still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = bus.mem_rdata;
    scan_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (ent_valid[scan_idx] && (ent_addr[scan_idx] == bus.ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[scan_idx];
      end
    end
  end

  assign bus.ld_fwd  = rst_n && fwd_hit;
  assign bus.ld_data = bus.ld_fwd ? fwd_data : bus.mem_rdata;

  // push and pop never target the same slot: that would need the buffer
  // to be both empty (no pop) and full (no push).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; it is qualified by ent_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.st_addr[31:2];
      ent_data[tail] <= bus.st_data;
    end
  end
endmodule
